rtc_hms_counter: RTL
====================

RTC_HMS_COUNTER -- requirements
Module: rtc_hms_counter

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, meaning clk cycles per second; legal range is 2 or more.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port clock_ena, input, 1 bit: run enable for the prescaler.
REQ-005 SHALL have port mode_12h, input, 1 bit: 1 selects 12-hour display, 0 selects 24-hour display.
REQ-006 SHALL have port position, input, 6 bits: one-hot edit select; bit0 u_seg through bit5 d_hours.
REQ-007 SHALL have port incre, input, 1 bit: edit increment request.
REQ-008 SHALL have port decre, input, 1 bit: edit decrement request.
REQ-009 SHALL have port load, input, 1 bit: bulk load strobe.
REQ-010 SHALL have port time_h_m_s, input, 6x8 bits: load value; digit i is in byte i [3:0]; byte 0 u_seg through byte 5 d_hours.
REQ-011 SHALL have port alarm_wr, input, 1 bit: alarm register write strobe.
REQ-012 SHALL have port alarm_h_m, input, 4x4 bits: alarm digits; nibble 0 u_min through nibble 3 d_hours.
REQ-013 SHALL have port alarm_on, input, 1 bit: alarm arm.
REQ-014 SHALL have outputs d_hours (2 bits), u_hours (4 bits), d_min, u_min, d_seg and u_seg (4 bits each): displayed BCD time.
REQ-015 SHALL have output pm, 1 bit: 1 when 12-hour mode is selected and the hour is 12 or later; 0 in 24-hour mode.
REQ-016 SHALL have output sec_tick, 1 bit: one-cycle pulse per second.
REQ-017 SHALL have output day_tick, 1 bit: one-cycle pulse on the 23:59:59 to 00:00:00 rollover.
REQ-018 SHALL have output load_err, 1 bit: one-cycle pulse when a load or alarm_wr is rejected.
REQ-019 SHALL have output alarm_match, 1 bit: one-cycle alarm pulse.

Function
REQ-020 The prescaler SHALL count 0 to CLK_FREQ_HZ-1 while clock_ena=1, hold while clock_ena=0, and wrap to 0; its width SHALL be $clog2(CLK_FREQ_HZ).
REQ-021 The tick SHALL assert when the prescaler is at CLK_FREQ_HZ-1 and clock_ena=1; sec_tick SHALL be registered, one cycle after the tick.
REQ-022 Time SHALL be held internally in 24-hour BCD; the range is 00:00:00 to 23:59:59.
REQ-023 On a tick the time SHALL advance by one second with BCD carries: u_seg 9 to 0, d_seg 5 to 0, u_min 9 to 0, d_min 5 to 0, and hours 23 to 00.
REQ-024 Time digit outputs SHALL update on the clock edge at which the tick is sampled.
REQ-025 Priority SHALL be: rst, then load, then tick, then edit; a lower-priority request in the same cycle SHALL be dropped.
REQ-026 Load SHALL accept the whole value only if all of these hold: u_seg and u_min are 9 or less, d_seg and d_min are 5 or less, and hours are 23 or less.
REQ-027 A rejected load SHALL leave the time unchanged and SHALL pulse load_err.
REQ-028 An accepted load SHALL clear the prescaler to 0.
REQ-029 An edit SHALL act only when position is exactly one-hot and exactly one of incre or decre is 1; otherwise no change.
REQ-030 Minute and second digit edits SHALL wrap within their digit range: units 0 to 9, tens 0 to 5.
REQ-031 Edit at position bit4 SHALL change the hour by ±1 and wrap 23 to 00.
REQ-032 Edit at position bit5 SHALL change the hour by ±10; if the result is outside 0 to 23, there SHALL be no change.
REQ-033 Edits SHALL NOT affect the prescaler, day_tick or alarm_match.
REQ-034 In 12-hour display, internal hour 00 SHALL show as 12 with pm=0.
REQ-035 In 12-hour display, internal hours 01 to 11 SHALL show unchanged with pm=0.
REQ-036 In 12-hour display, internal hour 12 SHALL show as 12 with pm=1.
REQ-037 In 12-hour display, internal hours 13 to 23 SHALL show hour-12 with pm=1.
REQ-038 The 12-hour conversion SHALL be display-only; internal state SHALL be unchanged by mode_12h.
REQ-039 load and edit values SHALL always be interpreted as 24-hour values.
REQ-040 day_tick SHALL pulse only on a tick-driven rollover, never on a load or edit to 00:00:00.

Reset
REQ-041 With rst=1, the prescaler and all time digits SHALL be 0.
REQ-042 With rst=1, the alarm register SHALL be 00:00.
REQ-043 With rst=1, sec_tick, day_tick, load_err and alarm_match SHALL be 0.
REQ-044 With rst=1, pm SHALL be 0.
REQ-045 rst SHALL override all other inputs in the same cycle, including while any operation is in progress.

Configuration
REQ-046 When RTC_ALARM_EN is defined, alarm_wr SHALL store alarm_h_m only if it is valid (mins 59 or less, hours 23 or less); an invalid write SHALL pulse load_err.
REQ-047 When RTC_ALARM_EN is defined, alarm_match SHALL pulse one cycle when a tick produces hh:mm:00 equal to the alarm while alarm_on=1; load or edit SHALL never trigger it.
REQ-048 When RTC_ALARM_EN is undefined, the alarm ports SHALL remain present and be ignored, alarm_match SHALL be constant 0, and no alarm registers SHALL exist.

Verification
REQ-049 The bench SHALL check that with CLK_FREQ_HZ=10 and clock_ena=1, 10 cycles give exactly one sec_tick, and u_seg goes 0 to 1.
REQ-050 The bench SHALL check that load 23:59:59 followed by one tick gives 00:00:00, a day_tick pulse, and load_err=0.
REQ-051 The bench SHALL check that load 24:00:00 gives load_err=1 and time unchanged.
REQ-052 The bench SHALL check that load 13:05:00 with mode_12h=1 displays 01:05:00 with pm=1, and 00:xx displays 12 with pm=0.
REQ-053 The bench SHALL check that an edit with position=bit5 and incre at 15:00:00 leaves time unchanged, and with position=bit4 and incre at 23:00:00 gives 00:00:00 with no day_tick.
REQ-054 The bench SHALL check that with RTC_ALARM_EN defined, alarm 07:30, alarm_on=1, load 07:29:59 and one tick gives alarm_match=1 for exactly one cycle; without the macro alarm_match stays 0.

Source files
------------

// File: rtl/rtc_hms_counter.sv
// rtc_hms_counter: BCD hh:mm:ss real-time clock with load, digit edit and 12/24h display; alarm built only with RTC_ALARM_EN.
module rtc_hms_counter #(
    parameter int CLK_FREQ_HZ = 100000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clock_ena,
    input  logic            mode_12h,
    input  logic [5:0]      position,
    input  logic            incre,
    input  logic            decre,
    input  logic            load,
    input  logic [5:0][7:0] time_h_m_s,
    input  logic            alarm_wr,
    input  logic [3:0][3:0] alarm_h_m,
    input  logic            alarm_on,
    output logic [1:0]      d_hours,
    output logic [3:0]      u_hours,
    output logic [3:0]      d_min,
    output logic [3:0]      u_min,
    output logic [3:0]      d_seg,
    output logic [3:0]      u_seg,
    output logic            pm,
    output logic            sec_tick,
    output logic            day_tick,
    output logic            load_err,
    output logic            alarm_match
);
    localparam int PW = $clog2(CLK_FREQ_HZ);

    function automatic logic [3:0] wrap(input logic [3:0] v, input logic [3:0] top, input logic up);
        return up ? (v == top ? 4'd0 : v + 4'd1) : (v == 4'd0 ? top : v - 4'd1);
    endfunction

    function automatic logic [5:0] bcd(input logic [4:0] h);
        return {h >= 5'd20 ? 2'd2 : h >= 5'd10 ? 2'd1 : 2'd0,
                h[3:0] - (h >= 5'd20 ? 4'd4 : h >= 5'd10 ? 4'd10 : 4'd0)};
    endfunction

    function automatic logic hour_ok(input logic [3:0] d, input logic [3:0] u);
        return (d < 4'd2 && u <= 4'd9) || (d == 4'd2 && u <= 4'd3);
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    us_q, ds_q, um_q, dm_q, uh_q;
    logic [3:0]    us_d, ds_d, um_d, dm_d, uh_d;
    logic [1:0]    dh_q, dh_d;
    logic          sec_q, day_q, day_d, err_q, err_d;
    logic          tick, adv, ed, ld_ok, ldv, up, alarm_err, c0, c1, c2, c3;
    logic [4:0]    hr, hr_n, hr12;
    logic          unused_bits;

    assign tick  = clock_ena && pre_q == PW'(CLK_FREQ_HZ - 1);
    assign ld_ok = time_h_m_s[0][3:0] <= 4'd9 && time_h_m_s[1][3:0] <= 4'd5 &&
                   time_h_m_s[2][3:0] <= 4'd9 && time_h_m_s[3][3:0] <= 4'd5 &&
                   hour_ok(time_h_m_s[5][3:0], time_h_m_s[4][3:0]);
    assign ldv   = load && ld_ok;
    assign adv   = tick && !load;
    assign ed    = !load && !tick && $onehot(position) && (incre ^ decre);
    assign up    = adv || incre;
    assign hr    = 5'(dh_q) * 5'd10 + 5'(uh_q);
    assign c0    = us_q == 4'd9;
    assign c1    = c0 && ds_q == 4'd5;
    assign c2    = c1 && um_q == 4'd9;
    assign c3    = c2 && dm_q == 4'd5;

    always_comb begin
        pre_d = ldv ? '0 : clock_ena ? (tick ? '0 : pre_q + 1'b1) : pre_q;
        us_d  = ldv ? time_h_m_s[0][3:0] : (adv || (ed && position[0])) ? wrap(us_q, 4'd9, up) : us_q;
        ds_d  = ldv ? time_h_m_s[1][3:0] : ((adv && c0) || (ed && position[1])) ? wrap(ds_q, 4'd5, up) : ds_q;
        um_d  = ldv ? time_h_m_s[2][3:0] : ((adv && c1) || (ed && position[2])) ? wrap(um_q, 4'd9, up) : um_q;
        dm_d  = ldv ? time_h_m_s[3][3:0] : ((adv && c2) || (ed && position[3])) ? wrap(dm_q, 4'd5, up) : dm_q;
        // Tens-of-hours edits that would leave 0..23 are ignored rather than wrapped
        hr_n  = ((adv && c3) || (ed && position[4])) ? (up ? (hr == 5'd23 ? 5'd0 : hr + 5'd1) : (hr == 5'd0 ? 5'd23 : hr - 5'd1)) :
                (ed && position[5]) ? (incre ? (hr <= 5'd13 ? hr + 5'd10 : hr) : (hr >= 5'd10 ? hr - 5'd10 : hr)) : hr;
        {dh_d, uh_d} = ldv ? {time_h_m_s[5][1:0], time_h_m_s[4][3:0]} : bcd(hr_n);
        day_d = adv && c3 && hr == 5'd23;
        err_d = (load && !ld_ok) || alarm_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            {dh_q, uh_q, dm_q, um_q, ds_q, us_q} <= '0;
            {sec_q, day_q, err_q} <= '0;
        end else begin
            pre_q <= pre_d;
            {dh_q, uh_q, dm_q, um_q, ds_q, us_q} <= {dh_d, uh_d, dm_d, um_d, ds_d, us_d};
            {sec_q, day_q, err_q} <= {tick, day_d, err_d};
        end
    end

`ifdef RTC_ALARM_EN
    logic [15:0] alarm_q;
    logic        al_ok, am_q, am_d;

    assign al_ok     = alarm_h_m[0] <= 4'd9 && alarm_h_m[1] <= 4'd5 && hour_ok(alarm_h_m[3], alarm_h_m[2]);
    assign alarm_err = alarm_wr && !al_ok;
    assign am_d      = adv && alarm_on && c1 && {2'b00, dh_d, uh_d, dm_d, um_d} == alarm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= '0;
            am_q    <= 1'b0;
        end else begin
            alarm_q <= (alarm_wr && al_ok) ? alarm_h_m : alarm_q;
            am_q    <= am_d;
        end
    end

    assign alarm_match = am_q;
    assign unused_bits = ^{time_h_m_s[0][7:4], time_h_m_s[1][7:4], time_h_m_s[2][7:4],
                           time_h_m_s[3][7:4], time_h_m_s[4][7:4], time_h_m_s[5][7:4]};
`else
    assign alarm_err   = 1'b0;
    assign alarm_match = 1'b0;
    assign unused_bits = ^{time_h_m_s[0][7:4], time_h_m_s[1][7:4], time_h_m_s[2][7:4],
                           time_h_m_s[3][7:4], time_h_m_s[4][7:4], time_h_m_s[5][7:4],
                           alarm_wr, alarm_h_m, alarm_on};
`endif

    assign hr12 = hr == 5'd0 ? 5'd12 : hr > 5'd12 ? hr - 5'd12 : hr;
    assign {d_hours, u_hours} = bcd(mode_12h ? hr12 : hr);
    assign {d_min, u_min, d_seg, u_seg} = {dm_q, um_q, ds_q, us_q};
    assign pm       = mode_12h && hr >= 5'd12;
    assign sec_tick = sec_q;
    assign day_tick = day_q;
    assign load_err = err_q;
endmodule
